// File: rtl/mem_map_pkg.sv
// Shared memory-map definitions for the core-side responder and the display controller.
`timescale 1ns/1ps
package mem_map_pkg;

    localparam int ADDR_W  = 20;   // core byte address width
    localparam int DATA_W  = 8;    // core data width
    localparam int VOFF_W  = 12;   // offset within a 4 KB region
    localparam int VQ_W    = VOFF_W + DATA_W;  // one video FIFO entry: {offset, byte}

    localparam int               DEF_RAM_BITS = 16;
    localparam logic [ADDR_W-1:0] DEF_ROM_BASE = 20'hFF000;
    localparam logic [ADDR_W-1:0] DEF_VID_BASE = 20'hB8000;
    localparam int               DEF_VQ_DEPTH = 8;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        RAM  = 2'd1,
        ROM  = 2'd2,
        VID  = 2'd3
    } region_t;

endpackage

// File: rtl/mem_bytefifo.sv
// Synchronous FIFO with an occupancy counter; the head is presented from storage
// without a read stage, so it is valid the cycle after the first push.
`timescale 1ns/1ps
module mem_bytefifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // Entry storage, written at the tail.
    // NOTE: storage has no reset; the pointers and count alone define which entries are live.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Core-side memory responder: decodes each byte access into RAM, ROM or video
// memory, returns read data with a fixed one-cycle latency and forwards video
// writes to the display controller through a small FIFO.
`timescale 1ns/1ps
module mem_responder
    import mem_map_pkg::*;
#(
    parameter int                 RAM_BITS = DEF_RAM_BITS,
    parameter logic [ADDR_W-1:0]  ROM_BASE = DEF_ROM_BASE,
    parameter logic [ADDR_W-1:0]  VID_BASE = DEF_VID_BASE,
    parameter int                 VQ_DEPTH = DEF_VQ_DEPTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [ADDR_W-1:0]    address,
    input  logic [DATA_W-1:0]    din,
    input  logic                 wren,
    output logic [DATA_W-1:0]    data,
    output logic [RAM_BITS-1:0]  ram_addr,
    output logic [DATA_W-1:0]    ram_wdata,
    output logic                 ram_we,
    input  logic [DATA_W-1:0]    ram_rdata,
    output logic [VOFF_W-1:0]    rom_addr,
    input  logic [DATA_W-1:0]    rom_rdata,
    output logic [VOFF_W-1:0]    vid_addr,
    output logic                 vid_we,
    input  logic [DATA_W-1:0]    vid_rdata,
    output logic                 vq_valid,
    input  logic                 vq_ready,
    output logic [VOFF_W-1:0]    vq_addr,
    output logic [DATA_W-1:0]    vq_data,
    output logic                 rom_wr_err,
    output logic                 vq_overflow
);

    localparam int VQ_CW = $clog2(VQ_DEPTH) + 1;

    region_t           region;
    region_t           region_q;
    logic              vq_push;
    logic              vq_pop;
    logic              vq_full;
    logic              vq_empty;
    logic [VQ_CW-1:0]  vq_count;
    logic [VQ_W-1:0]   vq_head;

    // Region decode; video wins over RAM where the two windows overlap.
    // NOTE: the default assignment up front keeps this combinational block latch-free.
    always_comb begin
        region = NONE;
        if (address[ADDR_W-1:VOFF_W] == VID_BASE[ADDR_W-1:VOFF_W]) begin
            region = VID;
        end else if ((address >> RAM_BITS) == '0) begin
            region = RAM;
        end else if (address >= ROM_BASE) begin
            region = ROM;
        end
    end

    assign ram_addr  = address[RAM_BITS-1:0];
    assign ram_wdata = din;
    assign ram_we    = wren & (region == RAM);
    assign rom_addr  = address[VOFF_W-1:0];
    assign vid_addr  = address[VOFF_W-1:0];
    assign vid_we    = wren & (region == VID);

    assign vq_push   = vid_we;
    assign vq_valid  = ~vq_empty;
    assign vq_pop    = vq_ready & (vq_count != '0);
    assign vq_addr   = vq_head[VQ_W-1:DATA_W];
    assign vq_data   = vq_head[DATA_W-1:0];

    mem_bytefifo #(
        .WIDTH (VQ_W),
        .DEPTH (VQ_DEPTH)
    ) u_vq (
        .clock (clock),
        .reset (reset),
        .push  (vq_push),
        .wdata ({address[VOFF_W-1:0], din}),
        .pop   (vq_pop),
        .rdata (vq_head),
        .full  (vq_full),
        .empty (vq_empty),
        .count (vq_count)
    );

    // Remember which region each access targeted so the read mux matches the 1-cycle memories.
    always_ff @(posedge clock) begin
        if (reset) region_q <= NONE;
        else       region_q <= region;
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            rom_wr_err  <= 1'b0;
            vq_overflow <= 1'b0;
        end else begin
            if (wren && region == ROM)        rom_wr_err  <= 1'b1;
            if (vq_push && vq_full && !vq_pop) vq_overflow <= 1'b1;
        end
    end

    // Read-data mux; unmapped space reads as all ones.
    always_comb begin
        unique case (region_q)
            RAM:     data = ram_rdata;
            ROM:     data = rom_rdata;
            VID:     data = vid_rdata;
            default: data = 8'hFF;
        endcase
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with behavioural 1-cycle RAM, ROM and video shadow models.
`timescale 1ns/1ps
module tb_mem_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic [19:0] address;
    logic [7:0]  din;
    logic        wren;
    logic [7:0]  data;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata;
    logic [11:0] rom_addr;
    logic [7:0]  rom_rdata;
    logic [11:0] vid_addr;
    logic        vid_we;
    logic [7:0]  vid_rdata;
    logic        vq_valid;
    logic        vq_ready;
    logic [11:0] vq_addr;
    logic [7:0]  vq_data;
    logic        rom_wr_err;
    logic        vq_overflow;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] ram_mem [65536];
    logic [7:0] rom_mem [4096];
    logic [7:0] vid_mem [4096];

    mem_responder dut (
        .clock       (clock),
        .reset       (reset),
        .address     (address),
        .din         (din),
        .wren        (wren),
        .data        (data),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_we      (ram_we),
        .ram_rdata   (ram_rdata),
        .rom_addr    (rom_addr),
        .rom_rdata   (rom_rdata),
        .vid_addr    (vid_addr),
        .vid_we      (vid_we),
        .vid_rdata   (vid_rdata),
        .vq_valid    (vq_valid),
        .vq_ready    (vq_ready),
        .vq_addr     (vq_addr),
        .vq_data     (vq_data),
        .rom_wr_err  (rom_wr_err),
        .vq_overflow (vq_overflow)
    );

    always #5 clock = ~clock;

    // Synchronous memories, read-before-write.
    always @(posedge clock) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
        rom_rdata <= rom_mem[rom_addr];
        if (vid_we) vid_mem[vid_addr] <= din;
        vid_rdata <= vid_mem[vid_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic acc(input logic [19:0] a, input logic [7:0] d, input logic w);
        address = a;
        din     = d;
        wren    = w;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram_mem[i] = 8'h00;
        for (int i = 0; i < 4096; i++) begin
            rom_mem[i] = 8'(i) ^ 8'hA5;
            vid_mem[i] = 8'h00;
        end
        rom_mem[12'hFF0] = 8'hC3;
        ram_rdata = 8'h00;
        rom_rdata = 8'h00;
        vid_rdata = 8'h00;

        reset = 1'b1; vq_ready = 1'b0;
        acc(20'h00000, 8'h00, 1'b0);
        tick(); tick();
        check("rst_data", data, 8'hFF);
        check("rst_vq_valid", vq_valid, 0);
        check("rst_rom_err", rom_wr_err, 0);
        check("rst_ovf", vq_overflow, 0);
        reset = 1'b0;

        // RAM write then read back with one-cycle latency.
        acc(20'h01234, 8'h5A, 1'b1);
        check("ram_we", ram_we, 1);
        check("ram_addr", ram_addr, 16'h1234);
        check("ram_wr_vid_we", vid_we, 0);
        tick();
        acc(20'h01234, 8'h00, 1'b0);
        tick();
        check("ram_read", data, 8'h5A);
        acc(20'h20000, 8'h11, 1'b1);
        check("none_ram_we", ram_we, 0);
        check("none_vid_we", vid_we, 0);
        wren = 1'b0;
        tick();
        check("none_read", data, 8'hFF);

        // RAM top boundary and the unmapped byte just above it.
        acc(20'h0FFFF, 8'h77, 1'b1);
        check("ram_top_we", ram_we, 1);
        tick();
        acc(20'h10000, 8'h66, 1'b1);
        check("above_ram_we", ram_we, 0);
        tick();
        acc(20'h0FFFF, 8'h00, 1'b0);
        tick();
        check("ram_top_read", data, 8'h77);

        // ROM read, write attempt and boundaries.
        acc(20'hFFFF0, 8'h00, 1'b0);
        check("rom_addr", rom_addr, 12'hFF0);
        tick();
        check("rom_read", data, 8'hC3);
        acc(20'hFFFF0, 8'h00, 1'b1);
        check("rom_wr_ram_we", ram_we, 0);
        tick();
        acc(20'hFFFF0, 8'h00, 1'b0);
        check("rom_wr_err", rom_wr_err, 1);
        tick();
        check("rom_reread", data, 8'hC3);
        acc(20'hFF000, 8'h00, 1'b0);
        tick();
        check("rom_base_read", data, 8'hA5);
        acc(20'hFEFFF, 8'h00, 1'b0);
        tick();
        check("below_rom_read", data, 8'hFF);

        // Video writes queue in order, hold while not ready, then drain.
        acc(20'hB8000, 8'h41, 1'b1);
        check("vid_we", vid_we, 1);
        check("vid_addr", vid_addr, 12'h000);
        check("vid_ram_we", ram_we, 0);
        tick();
        acc(20'hB8001, 8'h07, 1'b1);
        check("vq_valid_1", vq_valid, 1);
        tick();
        acc(20'hB8001, 8'h00, 1'b0);
        check("vq_count_2", dut.vq_count, 2);
        check("vq_head0_addr", vq_addr, 12'h000);
        check("vq_head0_data", vq_data, 8'h41);
        tick();
        check("vq_hold_data", vq_data, 8'h41);
        vq_ready = 1'b1;
        tick();
        check("vq_head1_addr", vq_addr, 12'h001);
        check("vq_head1_data", vq_data, 8'h07);
        tick();
        check("vq_drained", vq_valid, 0);
        vq_ready = 1'b0;
        acc(20'hB8000, 8'h00, 1'b0);
        tick();
        check("vid_read", data, 8'h41);

        // Overflow: nine writes into an eight-deep FIFO with no consumer.
        for (int i = 0; i < 9; i++) begin
            acc(20'hB8100 + 20'(i), 8'h10 + 8'(i), 1'b1);
            tick();
        end
        acc(20'hB8108, 8'h00, 1'b0);
        check("ovf_flag", vq_overflow, 1);
        check("ovf_count", dut.vq_count, 8);
        tick();
        check("ovf_shadow9", data, 8'h18);
        vq_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ovf_addr%0d", i), vq_addr, 12'h100 + 12'(i));
            check($sformatf("ovf_data%0d", i), vq_data, 8'h10 + 8'(i));
            tick();
        end
        check("ovf_empty", vq_valid, 0);
        vq_ready = 1'b0;

        // Full FIFO with a simultaneous push and pop.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_ovf", vq_overflow, 0);
        for (int i = 0; i < 8; i++) begin
            acc(20'hB8200 + 20'(i), 8'h20 + 8'(i), 1'b1);
            tick();
        end
        check("full_count", dut.vq_count, 8);
        acc(20'hB82FF, 8'hEE, 1'b1);
        vq_ready = 1'b1;
        tick();
        vq_ready = 1'b0;
        acc(20'hB82FF, 8'h00, 1'b0);
        check("pp_count", dut.vq_count, 8);
        check("pp_ovf", vq_overflow, 0);
        check("pp_head_addr", vq_addr, 12'h201);
        vq_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            check($sformatf("pp_data%0d", i), vq_data, 8'h20 + 8'(i));
            tick();
        end
        check("pp_tail_addr", vq_addr, 12'h2FF);
        check("pp_tail_data", vq_data, 8'hEE);
        tick();
        check("pp_empty", vq_valid, 0);
        vq_ready = 1'b0;

        // Reset with three entries queued and a sticky flag set.
        acc(20'hFF100, 8'h00, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            acc(20'hB8300 + 20'(i), 8'h30 + 8'(i), 1'b1);
            tick();
        end
        acc(20'hFFFF0, 8'h00, 1'b0);
        check("pre_rst_err", rom_wr_err, 1);
        check("pre_rst_count", dut.vq_count, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_valid", vq_valid, 0);
        check("mid_rst_data", data, 8'hFF);
        check("mid_rst_err", rom_wr_err, 0);
        check("mid_rst_ovf", vq_overflow, 0);
        acc(20'h01234, 8'h00, 1'b0);
        tick();
        check("post_rst_ram", data, 8'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
